// File: rtl/raster_line_queue_if.sv
// Line queue bundle: producer push side and rasterizer pop side.
// clk/rst stay outside so the bundle is purely data/handshake.
interface raster_line_queue_if #(
    parameter int CW    = 10,
    parameter int COLW  = 3,
    parameter int DEPTH = 4
);
    localparam int LW = 4 * CW + COLW + 1;
    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]   x_0;
    logic [CW-1:0]   y_0;
    logic [CW-1:0]   x_1;
    logic [CW-1:0]   y_1;
    logic [COLW-1:0] color;
    logic            EoO;
    logic            valid;
    logic            in_ready;
    logic            changed;
    logic [LW-1:0]   line_out;
    logic            out_valid;
    logic            out_ready;
    logic [AW:0]     count;
    logic            obj_done;
    logic            overflow;

    modport master (
        output x_0, y_0, x_1, y_1, color, EoO,
        output valid, changed, out_ready,
        input  in_ready, line_out, out_valid,
        input  count, obj_done, overflow
    );

    modport slave (
        input  x_0, y_0, x_1, y_1, color, EoO,
        input  valid, changed, out_ready,
        output in_ready, line_out, out_valid,
        output count, obj_done, overflow
    );
endinterface

// File: rtl/raster_line_queue.sv
// FWFT line queue between object walker and rasterizer.
// Optional endpoint ordering at push; flush on object-list change.
module raster_line_queue #(
    parameter int CW        = 10,
    parameter int COLW      = 3,
    parameter int DEPTH     = 4,
    parameter int NORMALIZE = 0
) (
    input logic            clk,
    input logic            rst,
    raster_line_queue_if.slave q
);
    localparam int LW = 4 * CW + COLW + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [LW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          obj_done_r;
    logic          overflow_r;
    logic          push;
    logic          pop;
    logic          swap;
    logic [LW-1:0] entry;

    // A pending flush blocks both sides in the same cycle.
    assign q.in_ready  = (cnt != FULL) && !q.changed;
    assign q.out_valid = (cnt != '0) && !q.changed;
    assign push        = q.valid && q.in_ready;
    assign pop         = q.out_valid && q.out_ready;
    assign q.line_out  = mem[rd_ptr];
    assign q.count     = cnt;
    assign q.obj_done  = obj_done_r;
    assign q.overflow  = overflow_r;

    // Order endpoints by (x, y) so lines always run left to right.
    always_comb begin
        swap = 1'b0;
        if (NORMALIZE != 0) begin
            swap = (q.x_0 > q.x_1) ||
                   ((q.x_0 == q.x_1) && (q.y_0 > q.y_1));
        end
        if (swap) begin
            entry = {q.x_1, q.y_1, q.x_0, q.y_0, q.color, q.EoO};
        end else begin
            entry = {q.x_0, q.y_0, q.x_1, q.y_1, q.color, q.EoO};
        end
    end

    // Storage is never cleared; only pointers define what is live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= entry;
        end
    end

    // Pointers, occupancy, end-of-object pulse and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            obj_done_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            obj_done_r <= pop && mem[rd_ptr][0];
            if (q.valid && (cnt == FULL) && !q.changed) begin
                overflow_r <= 1'b1;
            end
            if (q.changed) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    cnt <= cnt + (AW + 1)'(1);
                end else if (pop && !push) begin
                    cnt <= cnt - (AW + 1)'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_raster_line_queue.sv
// Bench for raster_line_queue: vector table, corner sequences,
// random traffic against a queue model; plain and normalizing DUTs.
module tb_raster_line_queue;
    localparam int CW    = 10;
    localparam int COLW  = 3;
    localparam int DEPTH = 4;
    localparam int LW    = 4 * CW + COLW + 1;

    typedef struct {
        logic [CW-1:0]   x0;
        logic [CW-1:0]   y0;
        logic [CW-1:0]   x1;
        logic [CW-1:0]   y1;
        logic [COLW-1:0] c;
        logic            e;
    } raw_t;

    typedef struct {
        bit r, v, ch, rd, e;
        int x;
        int ec;
        bit eov, eir, eod, eovf;
        int ehx;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    raw_t mq[$];
    bit   m_ov = 1'b0;
    bit   m_od = 1'b0;
    vec_t tbl[12];

    always #5 clk = ~clk;

    raster_line_queue_if #(.CW(CW), .COLW(COLW), .DEPTH(DEPTH)) b0();
    raster_line_queue_if #(.CW(CW), .COLW(COLW), .DEPTH(DEPTH)) b1();

    assign b1.x_0       = b0.x_0;
    assign b1.y_0       = b0.y_0;
    assign b1.x_1       = b0.x_1;
    assign b1.y_1       = b0.y_1;
    assign b1.color     = b0.color;
    assign b1.EoO       = b0.EoO;
    assign b1.valid     = b0.valid;
    assign b1.changed   = b0.changed;
    assign b1.out_ready = b0.out_ready;

    raster_line_queue #(
        .CW(CW), .COLW(COLW), .DEPTH(DEPTH), .NORMALIZE(0)
    ) dut0 (
        .clk(clk), .rst(rst), .q(b0.slave)
    );

    raster_line_queue #(
        .CW(CW), .COLW(COLW), .DEPTH(DEPTH), .NORMALIZE(1)
    ) dut1 (
        .clk(clk), .rst(rst), .q(b1.slave)
    );

    function automatic raw_t rw(int a, int b, int c, int d, int col, bit e);
        raw_t r;
        r.x0 = CW'(a);
        r.y0 = CW'(b);
        r.x1 = CW'(c);
        r.y1 = CW'(d);
        r.c  = COLW'(col);
        r.e  = e;
        return r;
    endfunction

    function automatic raw_t mk(int x, bit e);
        return rw(x, x + 1, x + 2, x + 3, (x + 4) % 8, e);
    endfunction

    function automatic logic [LW-1:0] pk(raw_t r);
        return {r.x0, r.y0, r.x1, r.y1, r.c, r.e};
    endfunction

    // Endpoints sorted lexicographically by (x, y).
    function automatic raw_t norm(raw_t r);
        raw_t o = r;
        if ({r.x0, r.y0} > {r.x1, r.y1}) begin
            o.x0 = r.x1;
            o.y0 = r.y1;
            o.x1 = r.x0;
            o.y1 = r.y0;
        end
        return o;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(bit r, bit v, bit ch, bit rd, raw_t l);
        rst          = r;
        b0.valid     = v;
        b0.changed   = ch;
        b0.out_ready = rd;
        b0.x_0       = l.x0;
        b0.y_0       = l.y0;
        b0.x_1       = l.x1;
        b0.y_1       = l.y1;
        b0.color     = l.c;
        b0.EoO       = l.e;
    endtask

    function automatic void model_edge();
        raw_t l;
        bit   can_push;
        bit   can_pop;
        l = rw(int'(b0.x_0), int'(b0.y_0), int'(b0.x_1), int'(b0.y_1),
               int'(b0.color), b0.EoO);
        if (rst) begin
            mq.delete();
            m_ov = 1'b0;
            m_od = 1'b0;
        end else if (b0.changed) begin
            mq.delete();
            m_od = 1'b0;
        end else begin
            can_push = mq.size() < DEPTH;
            can_pop  = mq.size() > 0;
            m_od     = 1'b0;
            if (b0.valid && !can_push) m_ov = 1'b1;
            if (b0.out_ready && can_pop) begin
                m_od = mq[0].e;
                void'(mq.pop_front());
            end
            if (b0.valid && can_push) mq.push_back(l);
        end
    endfunction

    task automatic check_model();
        chk("count", b0.count, mq.size());
        chk("in_ready", b0.in_ready, (mq.size() != DEPTH) && !b0.changed);
        chk("out_valid", b0.out_valid, (mq.size() != 0) && !b0.changed);
        chk("obj_done", b0.obj_done, m_od);
        chk("overflow", b0.overflow, m_ov);
        chk("n_count", b1.count, mq.size());
        chk("n_overflow", b1.overflow, m_ov);
        if (mq.size() != 0) begin
            chk("line_out", b0.line_out, pk(mq[0]));
            chk("n_line_out", b1.line_out, pk(norm(mq[0])));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        tbl = '{
            '{1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, -1},
            '{0, 1, 0, 0, 0,  1, 1, 1, 1, 0, 0,  1},
            '{0, 1, 0, 0, 0, 10, 2, 1, 1, 0, 0,  1},
            '{0, 1, 0, 0, 0, 20, 3, 1, 1, 0, 0,  1},
            '{0, 1, 0, 0, 1, 30, 4, 1, 0, 0, 0,  1},
            '{0, 1, 0, 0, 0, 40, 4, 1, 0, 0, 1,  1},
            '{0, 0, 0, 1, 0,  0, 3, 1, 1, 0, 1, 10},
            '{0, 0, 0, 1, 0,  0, 2, 1, 1, 0, 1, 20},
            '{0, 0, 0, 1, 0,  0, 1, 1, 1, 0, 1, 30},
            '{0, 0, 0, 1, 0,  0, 0, 0, 1, 1, 1, -1},
            '{0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, -1},
            '{1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, -1}
        };

        drive(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1'b0));
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].ch, tbl[i].rd,
                  mk(tbl[i].x, tbl[i].e));
            step();
            chk("t_count", b0.count, tbl[i].ec);
            chk("t_out_valid", b0.out_valid, tbl[i].eov);
            chk("t_in_ready", b0.in_ready, tbl[i].eir);
            chk("t_obj_done", b0.obj_done, tbl[i].eod);
            chk("t_overflow", b0.overflow, tbl[i].eovf);
            if (tbl[i].ehx >= 0)
                chk("t_head_x", b0.line_out[LW-1 -: CW], tbl[i].ehx);
            if (i == 1)
                chk("t_first_line", b0.line_out, pk(rw(1, 2, 3, 4, 5, 0)));
        end

        // Endpoint ordering on the normalizing instance.
        drive(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1'b0));
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, rw(9, 1, 2, 7, 6, 1'b1));
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, rw(5, 8, 5, 3, 2, 1'b0));
        step();
        chk("norm_swap_x", b1.line_out, pk(rw(2, 7, 9, 1, 6, 1'b1)));
        chk("plain_keep", b0.line_out, pk(rw(9, 1, 2, 7, 6, 1'b1)));
        drive(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 1'b0));
        step();
        chk("norm_swap_y", b1.line_out, pk(rw(5, 3, 5, 8, 2, 1'b0)));

        // Flush with a push and pop in the same cycle.
        drive(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1'b0));
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, mk(50, 1'b1));
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, mk(60, 1'b1));
        step();
        chk("fl_pre_count", b0.count, 2);
        drive(1'b0, 1'b1, 1'b1, 1'b1, mk(70, 1'b1));
        step();
        chk("fl_count", b0.count, 0);
        chk("fl_obj_done", b0.obj_done, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 1'b0));
        #1;
        chk("fl_out_valid", b0.out_valid, 0);
        chk("fl_in_ready", b0.in_ready, 1);
        step();
        chk("fl_obj_done2", b0.obj_done, 0);

        // Steady push/pop at one entry, wrapping the pointers.
        drive(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1'b0));
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, mk(100, 1'b0));
        step();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, mk(200 + k, k == 4));
            step();
            chk("ss_count", b0.count, 1);
            chk("ss_head_x", b0.line_out[LW-1 -: CW], 200 + k);
            chk("ss_obj_done", b0.obj_done, k == 5);
        end

        // Reset mid-stream with overflow set.
        drive(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1'b0));
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, mk(300 + k, 1'b1));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 1'b0));
        step();
        chk("rs_pre_count", b0.count, 3);
        chk("rs_pre_ovf", b0.overflow, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, mk(400, 1'b1));
        step();
        chk("rs_count", b0.count, 0);
        chk("rs_ovf", b0.overflow, 0);
        chk("rs_obj_done", b0.obj_done, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 1'b0));
        #1;
        chk("rs_out_valid", b0.out_valid, 0);
        chk("rs_in_ready", b0.in_ready, 1);

        // Random traffic with small coordinates to hit ties.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 2) != 0,
                  rw($urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), 1'($urandom_range(0, 1))));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/raster_line_queue.md
RASTER_LINE_QUEUE -- requirements
Module: raster_line_queue

Interface
REQ-001 Parameter CW, default 10: coordinate width per axis in bits, minimum 4.
REQ-002 Parameter COLW, default 3: color width in bits, minimum 1.
REQ-003 Parameter DEPTH, default 4: queue entries; must be a power of 2 and at least 2.
REQ-004 Parameter NORMALIZE, default 0: 1 enables endpoint ordering at push.
REQ-005 Derived LW = 4*CW+COLW+1 (packed entry width) and AW = log2(DEPTH).
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 x_0, y_0, x_1, y_1  in  CW each  line endpoint coordinates (unsigned).
REQ-010 color  in  COLW  line color.
REQ-011 EoO  in  1  end-of-object marker, carried with the line.
REQ-012 valid  in  1  producer has a line this cycle.
REQ-013 in_ready  out  1  queue accepts a line this cycle.
REQ-014 changed  in  1  frame/object-list changed; flushes the queue.
REQ-015 line_out  out  LW  head entry, packed as {x_0, y_0, x_1, y_1, color, EoO}.
REQ-016 out_valid  out  1  line_out is valid.
REQ-017 out_ready  in  1  rasterizer consumes the head.
REQ-018 count  out  AW+1  number of occupied entries.
REQ-019 obj_done  out  1  one-cycle pulse when an entry with EoO=1 is popped.
REQ-020 overflow  out  1  sticky; set when a push is attempted while full.

Function
REQ-021 Push occurs when valid and in_ready are both 1 at a rising edge.
REQ-022 Pop occurs when out_valid and out_ready are both 1 at a rising edge.
REQ-023 in_ready SHALL equal (count != DEPTH) and not changed, combinationally.
REQ-024 out_valid SHALL equal (count != 0) and not changed, combinationally.
REQ-025 line_out SHALL present the oldest entry combinationally (first-word fall-through); its value when out_valid=0 is don't-care.
REQ-026 The queue is strictly FIFO; write and read pointers are AW bits and wrap from DEPTH-1 to 0.
REQ-027 Simultaneous push and pop when full: in_ready=0, so only the pop occurs.
REQ-028 Simultaneous push and pop when 0 < count < DEPTH: both occur and count is unchanged.
REQ-029 Push when empty: out_valid=1 in the next cycle (latency 1) with the pushed line.
REQ-030 NORMALIZE=1: if x_0 > x_1 at push, store (x_1, y_1) as the first endpoint and (x_0, y_0) as the second; otherwise store as given.
REQ-031 NORMALIZE=1: when x_0 = x_1 and y_0 > y_1, also swap the endpoints; color and EoO are never altered.
REQ-032 changed=1 at a rising edge: pointers and count go to 0; the same-cycle push and pop are both suppressed (per REQ-023 and REQ-024).
REQ-033 obj_done SHALL be registered, asserting in the cycle after a pop whose entry has EoO=1.
REQ-034 overflow SHALL be set at the edge where valid=1 and count=DEPTH and changed=0, and holds until reset; the line is dropped.
REQ-035 Storage contents are not cleared by flush or reset; only pointers and count reset.

Reset
REQ-036 While rst=1 at a rising edge: count=0, pointers=0, obj_done=0, overflow=0.
REQ-037 After reset, in_ready=1 (if changed=0) and out_valid=0.
REQ-038 Reset takes priority over push, pop, and changed.
REQ-039 A reset mid-stream discards all queued lines; no obj_done pulse occurs for them.

Verification
REQ-040 Reset, then push (1,2,3,4,color 5,EoO 0) -> next cycle out_valid=1, line_out={1,2,3,4,5,0}, count=1.
REQ-041 DEPTH=4: push 4 lines with out_ready=0 -> count=4, in_ready=0; a 5th push attempt -> overflow=1 and the queue is unchanged; then pop all -> lines return in order.
REQ-042 NORMALIZE=1: push (x_0=9,y_0=1,x_1=2,y_1=7) -> stored as {2,7,9,1}; push (5,8,5,3) -> stored as {5,3,5,8}.
REQ-043 count=2 with changed=1, valid=1, out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, no obj_done.
REQ-044 Continuous push and pop at count=1 for 10 cycles -> count stays 1, order is preserved, pointers wrap; popping an EoO=1 entry -> obj_done high for exactly one cycle.
REQ-045 Assert rst with count=3 and overflow=1 -> next cycle count=0, overflow=0, out_valid=0.
